// File: rtl/enable_gen_pkg.sv
// Shared defaults and helpers for the enable_gen clock-enable generator.
package enable_gen_pkg;

    localparam int DIV_W_DEF   = 16;
    localparam int DIV_RST_DEF = 190;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int sel_width(input int nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/enable_gen_ch.sv
// One enable channel: active/shadow divisor, pending flag and terminal-count down-counter.
// Optional phase-align input is present only when ENABLE_GEN_SYNC_EN is defined.
module enable_gen_ch
    import enable_gen_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_i,
`ifdef ENABLE_GEN_SYNC_EN
    input  logic             sync_i,
`endif
    input  logic             wr_i,
    input  logic [DIV_W-1:0] data_i,
    output logic             en_o,
    output logic             sq_o
);

    localparam logic [DIV_W-1:0] RST_D = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] RST_C = (RST_D == '0) ? '0 : RST_D - DIV_W'(1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             sq_q, sq_d;

    // Divisors 0 and 1 both reload to 0, which makes every running cycle terminal.
    function automatic logic [DIV_W-1:0] dec_sat(input logic [DIV_W-1:0] v);
        return (v == '0) ? '0 : v - DIV_W'(1);
    endfunction

    always_comb begin
        div_d  = div_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        en_d   = 1'b0;
        sq_d   = sq_q;
`ifdef ENABLE_GEN_SYNC_EN
        if (sync_i) begin
            if (pend_q) begin
                div_d  = shd_q;
                pend_d = 1'b0;
            end
            cnt_d = dec_sat(pend_q ? shd_q : div_q);
            sq_d  = 1'b0;
        end else
`endif
        if (run_i) begin
            if (cnt_q == '0) begin
                en_d = 1'b1;
                sq_d = ~sq_q;
                if (pend_q) begin
                    div_d  = shd_q;
                    pend_d = 1'b0;
                    cnt_d  = dec_sat(shd_q);
                end else begin
                    cnt_d = dec_sat(div_q);
                end
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end
        // A write landing on a terminal count only arms the next one.
        if (wr_i) begin
            shd_d  = data_i;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= RST_D;
            shd_q  <= RST_D;
            pend_q <= 1'b0;
            cnt_q  <= RST_C;
            en_q   <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            sq_q   <= sq_d;
        end
    end

    assign en_o = en_q;
    assign sq_o = sq_q;

endmodule

// File: rtl/enable_gen.sv
// Multi-channel enable/square-wave generator with shadowed divisor writes.
// Define ENABLE_GEN_SYNC_EN to add the sync input that phase-aligns all channels.
module enable_gen
    import enable_gen_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_RST = DIV_RST_DEF,
    localparam int SEL_W  = sel_width(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
`ifdef ENABLE_GEN_SYNC_EN
    input  logic             sync,
`endif
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [DIV_W-1:0] div_data,
    output logic             div_ack,
    output logic [NCH-1:0]   en_out,
    output logic [NCH-1:0]   sq_out
);

    logic wr_hit;
    logic ack_q, ack_d;

    // Out-of-range selects are dropped silently and never acknowledged.
    assign wr_hit = div_wr && ({1'b0, div_sel} < (SEL_W + 1)'(NCH));

    always_comb begin
        ack_d = wr_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end

    assign div_ack = ack_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        enable_gen_ch #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .run_i  (run),
`ifdef ENABLE_GEN_SYNC_EN
            .sync_i (sync),
`endif
            .wr_i   (wr_hit && (div_sel == SEL_W'(i))),
            .data_i (div_data),
            .en_o   (en_out[i]),
            .sq_o   (sq_out[i])
        );
    end

endmodule

// File: tb/tb_enable_gen.sv
// Directed bench for enable_gen; three channels so that div_sel=3 is an out-of-range select.
module tb_enable_gen;

    localparam int NCH   = 3;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
`ifdef ENABLE_GEN_SYNC_EN
    logic             sync;
`endif
    logic             div_wr;
    logic [1:0]       div_sel;
    logic [DIV_W-1:0] div_data;
    logic             div_ack;
    logic [NCH-1:0]   en_out;
    logic [NCH-1:0]   sq_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    enable_gen #(.NCH(NCH), .DIV_W(DIV_W), .DIV_RST(190)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
`ifdef ENABLE_GEN_SYNC_EN
        .sync     (sync),
`endif
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_data (div_data),
        .div_ack  (div_ack),
        .en_out   (en_out),
        .sq_out   (sq_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [DIV_W-1:0] data);
        div_wr   = 1'b1;
        div_sel  = sel;
        div_data = data;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; div_wr = 1'b0; div_sel = '0; div_data = '0;
`ifdef ENABLE_GEN_SYNC_EN
        sync = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_en", en_out, 0);
        chk("rst_sq", sq_out, 0);
        chk("rst_ack", div_ack, 0);

        reset = 1'b0; run = 1'b1; cyc = 0;
        run_to(50);  wr(1, 4);
        tick();      chk("ack_51", div_ack, 1); div_wr = 1'b0;
        tick();      chk("ack_52", div_ack, 0);
        run_to(189); chk("en_189", en_out, 3'b000);
        tick();      chk("en_190", en_out, 3'b111);
                     chk("sq_190", sq_out, 3'b111);
        tick();      chk("en_191", en_out, 3'b000);
        run_to(194); chk("en_194", en_out, 3'b010);
                     chk("sq_194", sq_out, 3'b101);
        run_to(198); chk("en_198", en_out, 3'b010);
                     chk("sq_198", sq_out, 3'b111);
        run_to(380); chk("en_380", en_out, 3'b101);
                     chk("sq_380", sq_out, 3'b000);

        // last write wins; out-of-range select ignored
        run_to(400); wr(2, 10);
        tick();      chk("ack_401", div_ack, 1); div_data = 20;
        tick();      chk("ack_402", div_ack, 1); div_sel = 2'd3; div_data = 5;
        tick();      chk("ack_bad", div_ack, 0); div_wr = 1'b0;
        run_to(570); chk("en_570", en_out, 3'b111);
        run_to(580); chk("en_580", en_out, 3'b000);
        run_to(590); chk("en_590", en_out, 3'b110);

        // divisor 1 then 0 on channel 0
        run_to(600); wr(0, 1);
        tick();      div_data = 0;
        tick();      div_wr = 1'b0;
        run_to(760); chk("en_760", en_out, 3'b001);
        tick();      chk("en_761", en_out, 3'b001);
        tick();      chk("en_762", en_out, 3'b011);
                     chk("sq_762", sq_out, 3'b000);
        tick();      chk("en_763", en_out, 3'b001); run = 1'b0;
        tick();      chk("en_frz", en_out, 3'b000);
        run_to(770); chk("en_770", en_out, 3'b000);
                     chk("sq_770", sq_out, 3'b001);
        run_to(793); run = 1'b1;
        tick();      chk("en_794", en_out, 3'b001);
        run_to(796); chk("en_796", en_out, 3'b011);
        run_to(800); chk("en_800", en_out, 3'b111);

        // pending write discarded by reset, then run dropped for 30 cycles
        run_to(805); wr(2, 7);
        tick();      chk("ack_806", div_ack, 1); div_wr = 1'b0; reset = 1'b1;
        tick();      chk("rst2_ack", div_ack, 0);
                     chk("rst2_en", en_out, 0);
                     chk("rst2_sq", sq_out, 0);
        tick();
        reset = 1'b0; cyc = 0;
        run_to(99);  run = 1'b0;
        run_to(129); run = 1'b1;
        run_to(219); chk("en_219", en_out, 3'b000);
        tick();      chk("en_220", en_out, 3'b111);
        run_to(227); chk("en_227", en_out, 3'b000);
        run_to(410); chk("en_410", en_out, 3'b111);

`ifdef ENABLE_GEN_SYNC_EN
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0; cyc = 0; wr(0, 7);
        tick();      wr(1, 11);
        tick();      div_wr = 1'b0; sync = 1'b1;
        tick();      sync = 1'b0;
                     chk("sync_en", en_out, 3'b000);
                     chk("sync_sq", sq_out, 3'b000);
        run_to(10);  chk("sync_c0", en_out, 3'b001);
        run_to(14);  chk("sync_c1", en_out, 3'b010);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
